// File: rtl/sr_drift_scheduler_pkg.sv
// Shared types and default constants for the Schumann-resonance drift scheduler.
// Interval defaults select between a one-tick simulation step and the minutes-scale real step.
package sr_drift_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_SCAN,
      ST_REQ,
      ST_DONE
   } state_t;

   localparam int NUM_HARMONICS_DEF = 5;
   localparam int IDX_W_DEF         = 3;
   localparam int INTERVAL_W_DEF    = 24;
   localparam int EPOCH_W_DEF       = 16;
   localparam int ACK_TIMEOUT_DEF   = 16;

   // 48 kHz sample ticks times 60 s gives one drift step per minute.
   localparam bit FAST_SIM      = 1'b0;
   localparam int INTERVAL_FAST = 1;
   localparam int INTERVAL_REAL = 2880000;
   localparam int INTERVAL_DEF  = FAST_SIM ? INTERVAL_FAST : INTERVAL_REAL;

   function automatic logic is_busy_state(input state_t s);
      return (s == ST_SCAN) || (s == ST_REQ) || (s == ST_DONE);
   endfunction

endpackage

// File: rtl/sr_drift_scheduler_if.sv
// Request/acknowledge link between the scheduler and the shared random-walk/clamp datapath.
interface sr_drift_scheduler_if
   import sr_drift_pkg::*;
#(
   parameter int IDX_W = IDX_W_DEF
);
   logic             upd_req;
   logic [IDX_W-1:0] upd_idx;
   logic             upd_ack;

   modport master (output upd_req, output upd_idx, input  upd_ack);
   modport slave  (input  upd_req, input  upd_idx, output upd_ack);
endinterface

// File: rtl/sr_drift_scheduler_tick_divider.sv
// Counts sample-rate ticks against a latched interval and strobes on the terminal tick.
// A zero interval is latched as one so every tick terminates.
module sr_tick_divider
   import sr_drift_pkg::*;
#(
   parameter int INTERVAL_W = INTERVAL_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_clk_en,
   input  logic                  i_count,
   input  logic                  i_load,
   input  logic [INTERVAL_W-1:0] i_interval_cfg,
   output logic                  o_tc
);

   logic [INTERVAL_W-1:0] r_interval;
   logic [INTERVAL_W-1:0] r_cnt;

   assign o_tc = i_count && i_clk_en && (r_cnt == (r_interval - INTERVAL_W'(1)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_interval <= INTERVAL_W'(1);
         r_cnt      <= '0;
      end else if (i_load) begin
         r_interval <= (i_interval_cfg == '0) ? INTERVAL_W'(1) : i_interval_cfg;
         r_cnt      <= '0;
      end else if (i_count && i_clk_en) begin
         r_cnt <= o_tc ? '0 : (r_cnt + INTERVAL_W'(1));
      end
   end

endmodule

// File: rtl/sr_drift_scheduler.sv
// Epoch sequencer: waits out the tick interval, then requests one drift update per
// unfrozen harmonic in index order, guarded by an acknowledge watchdog.
module sr_drift_scheduler
   import sr_drift_pkg::*;
#(
   parameter int NUM_HARMONICS = NUM_HARMONICS_DEF,
   parameter int IDX_W         = IDX_W_DEF,
   parameter int INTERVAL_W    = INTERVAL_W_DEF,
   parameter int ACK_TIMEOUT   = ACK_TIMEOUT_DEF,
   parameter int EPOCH_W       = EPOCH_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_clk_en,
   input  logic                     i_enable,
   input  logic [INTERVAL_W-1:0]    i_interval_cfg,
   input  logic [NUM_HARMONICS-1:0] i_hold_mask,
   sr_drift_scheduler_if.master     upd_bus,
   output logic                     o_epoch_done,
   output logic [EPOCH_W-1:0]       o_epoch_count,
   output logic                     o_busy,
   output logic                     o_timeout_err
);

   localparam int WD_W = $clog2(ACK_TIMEOUT + 1);

   state_t             r_state, w_state_next;
   logic [IDX_W-1:0]   r_idx, w_idx_next;
   logic [WD_W-1:0]    r_wdog, w_wdog_next;
   logic               r_upd_req, r_epoch_done, r_busy, r_timeout_err;
   logic [EPOCH_W-1:0] r_epoch_count;
   logic               w_load, w_tc, w_timeout, w_hold_cur, w_last;
   logic [NUM_HARMONICS-1:0] w_hold_hit;

   // Mask lookup built per harmonic so an out-of-range index simply reads as unheld.
   for (genvar gi = 0; gi < NUM_HARMONICS; gi++) begin : g_hold
      assign w_hold_hit[gi] = i_hold_mask[gi] && (r_idx == IDX_W'(gi));
   end
   assign w_hold_cur = |w_hold_hit;
   assign w_last     = (r_idx == IDX_W'(NUM_HARMONICS - 1));

   sr_tick_divider #(.INTERVAL_W(INTERVAL_W)) u_div (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_clk_en       (i_clk_en),
      .i_count        ((r_state == ST_WAIT) && i_enable),
      .i_load         (w_load),
      .i_interval_cfg (i_interval_cfg),
      .o_tc           (w_tc)
   );

   always_comb begin
      w_state_next = r_state;
      w_idx_next   = r_idx;
      w_wdog_next  = '0;
      w_load       = 1'b0;
      w_timeout    = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (i_enable) begin
               w_load       = 1'b1;
               w_state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!i_enable) begin
               w_state_next = ST_IDLE;
            end else if (w_tc) begin
               w_idx_next   = '0;
               w_state_next = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (!w_hold_cur)  w_state_next = ST_REQ;
            else if (w_last)  w_state_next = ST_DONE;
            else              w_idx_next   = r_idx + IDX_W'(1);
         end
         ST_REQ: begin
            w_wdog_next = r_wdog + WD_W'(1);
            // Ack wins over a coincident watchdog expiry.
            if (upd_bus.upd_ack || (r_wdog == WD_W'(ACK_TIMEOUT - 1))) begin
               w_timeout   = !upd_bus.upd_ack;
               w_wdog_next = '0;
               if (w_last) begin
                  w_state_next = ST_DONE;
               end else begin
                  w_idx_next   = r_idx + IDX_W'(1);
                  w_state_next = ST_SCAN;
               end
            end
         end
         ST_DONE: begin
            w_load       = i_enable;
            w_state_next = i_enable ? ST_WAIT : ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_idx         <= '0;
         r_wdog        <= '0;
         r_upd_req     <= 1'b0;
         r_epoch_done  <= 1'b0;
         r_busy        <= 1'b0;
         r_timeout_err <= 1'b0;
         r_epoch_count <= '0;
      end else begin
         r_state       <= w_state_next;
         r_idx         <= w_idx_next;
         r_wdog        <= w_wdog_next;
         r_upd_req     <= (w_state_next == ST_REQ);
         r_epoch_done  <= (w_state_next == ST_DONE);
         r_busy        <= is_busy_state(w_state_next);
         r_timeout_err <= r_timeout_err || w_timeout;
         if (w_state_next == ST_DONE) r_epoch_count <= r_epoch_count + EPOCH_W'(1);
      end
   end

   assign upd_bus.upd_req = r_upd_req;
   assign upd_bus.upd_idx = r_idx;
   assign o_epoch_done    = r_epoch_done;
   assign o_epoch_count   = r_epoch_count;
   assign o_busy          = r_busy;
   assign o_timeout_err   = r_timeout_err;

endmodule
